// File: rtl/tetris_gravity_timer.sv
// Gravity event generator: turns divider ticks into drop/lock request/acknowledge handshakes.
// Optional feature macro: GRAVITY_OVERRUN_EN builds the sticky overrun flag.
module tetris_gravity_timer #(
  parameter int unsigned BASE_TICKS = 8,
  parameter int unsigned LOCK_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       pause,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       landed,
  input  logic       drop_ack,
  input  logic       lock_ack,
  output logic       drop_req,
  output logic       lock_req,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DROP_REQ,
    LOCK_WAIT,
    LOCK_REQ
  } state_t;

  localparam logic [7:0] BASE = 8'(BASE_TICKS);
  localparam logic [7:0] LOCK = 8'(LOCK_TICKS);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] interval;
  logic [8:0] cnt_inc;
  logic       interval_hit;
  logic       lock_hit;

  // Clamp at 1 tick once the level reaches BASE-1 so the subtraction never wraps.
  always_comb begin
    interval = 8'd1;
    if (!soft_drop && (BASE > ({4'd0, level} + 8'd1)))
      interval = BASE - {4'd0, level};
  end

  // Compare with >= in 9 bits: a shrinking interval expires on the next tick, never after wrap.
  assign cnt_inc      = {1'b0, cnt} + 9'd1;
  assign interval_hit = cnt_inc >= {1'b0, interval};
  assign lock_hit     = cnt_inc >= {1'b0, LOCK};

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!pause) begin
            state_next = COUNT;
            cnt_next   = 8'd0;
          end
        end
        COUNT: begin
          if (!pause && tick) begin
            if (interval_hit) begin
              state_next = landed ? LOCK_WAIT : DROP_REQ;
              cnt_next   = 8'd0;
            end else begin
              cnt_next = cnt_inc[7:0];
            end
          end
        end
        // Acks complete the handshake even while paused.
        DROP_REQ: begin
          if (drop_ack) begin
            state_next = COUNT;
            cnt_next   = 8'd0;
          end
        end
        LOCK_WAIT: begin
          if (!pause) begin
            if (!landed) begin
              state_next = COUNT;
              cnt_next   = 8'd0;
            end else if (tick) begin
              if (lock_hit) begin
                state_next = LOCK_REQ;
                cnt_next   = 8'd0;
              end else begin
                cnt_next = cnt_inc[7:0];
              end
            end
          end
        end
        LOCK_REQ: begin
          if (lock_ack) begin
            state_next = COUNT;
            cnt_next   = 8'd0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      drop_req <= 1'b0;
      lock_req <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      drop_req <= (state_next == DROP_REQ);
      lock_req <= (state_next == LOCK_REQ);
    end
  end

`ifdef GRAVITY_OVERRUN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (!enable) begin
      overrun <= 1'b0;
    end else if (tick && !pause && ((state == DROP_REQ) || (state == LOCK_REQ))) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_tetris_gravity_timer.sv
// Directed bench for tetris_gravity_timer: drop interval, clamp, soft drop, lock, overrun, pause, reset.
module tb_tetris_gravity_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] level = 4'd0;
  logic       soft_drop = 1'b0;
  logic       landed = 1'b0;
  logic       drop_ack = 1'b0;
  logic       lock_ack = 1'b0;
  logic       drop_req;
  logic       lock_req;
  logic       overrun;

  int total = 0;
  int bad = 0;

`ifdef GRAVITY_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  tetris_gravity_timer #(.BASE_TICKS(8), .LOCK_TICKS(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .pause(pause),
    .level(level), .soft_drop(soft_drop), .landed(landed),
    .drop_ack(drop_ack), .lock_ack(lock_ack),
    .drop_req(drop_req), .lock_req(lock_req), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; outputs are read at the negedge after each rising edge.
  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    idle_cycle();
    tick = 1'b0;
    idle_cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  task automatic expect_drop_after(input string tag, input int n);
    ticks(n - 1);
    check({tag, "_early"}, drop_req, 1'b0);
    pulse_tick();
    check(tag, drop_req, 1'b1);
  endtask

  task automatic ack_drop(input string tag);
    drop_ack = 1'b1;
    idle_cycle();
    drop_ack = 1'b0;
    check(tag, drop_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_drop", drop_req, 1'b0);
    check("rst_lock", lock_req, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    level = 4'd3;
    idle_cycle();

    // level 3: interval 5
    expect_drop_after("lvl3_a", 5);
    ack_drop("lvl3_a_ack");
    expect_drop_after("lvl3_b", 5);
    ack_drop("lvl3_b_ack");

    // level 12 clamps to 1 tick
    level = 4'd12;
    for (int i = 0; i < 3; i++) begin
      expect_drop_after("lvl12", 1);
      ack_drop("lvl12_ack");
    end

    // level raise mid-count: cnt=4, I 8 -> 2 expires on next tick
    level = 4'd0;
    ticks(4);
    check("raise_pre", drop_req, 1'b0);
    level = 4'd6;
    pulse_tick();
    check("raise_hit", drop_req, 1'b1);
    ack_drop("raise_ack");

    // soft drop at level 0
    level = 4'd0;
    soft_drop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_drop_after("soft", 1);
      ack_drop("soft_ack");
    end
    soft_drop = 1'b0;
    expect_drop_after("soft_rel", 8);
    ack_drop("soft_rel_ack");

    // lock path, I = 2
    level = 4'd6;
    landed = 1'b1;
    ticks(2);
    check("lk_wait_drop", drop_req, 1'b0);
    check("lk_wait_lock", lock_req, 1'b0);
    pulse_tick();
    check("lk_first", lock_req, 1'b0);
    pulse_tick();
    check("lk_req", lock_req, 1'b1);
    lock_ack = 1'b1;
    idle_cycle();
    lock_ack = 1'b0;
    check("lk_ack", lock_req, 1'b0);

    // landed drops after one tick in LOCK_WAIT
    ticks(2);
    pulse_tick();
    landed = 1'b0;
    idle_cycle();
    check("lk_abort", lock_req, 1'b0);
    expect_drop_after("lk_restart", 2);
    check("lk_restart_lock", lock_req, 1'b0);
    ack_drop("lk_restart_ack");

    // overrun: ack withheld across 3 ticks
    expect_drop_after("ovr_drop", 2);
    ticks(3);
    check("ovr_req_held", drop_req, 1'b1);
    check("ovr_set", overrun, OVR_EXP);
    ack_drop("ovr_ack");
    check("ovr_sticky", overrun, OVR_EXP);
    enable = 1'b0;
    idle_cycle();
    check("dis_ovr", overrun, 1'b0);
    check("dis_drop", drop_req, 1'b0);
    enable = 1'b1;
    idle_cycle();

    // pause freezes cnt: 3 ticks before, 10 ignored, 5 after
    level = 4'd0;
    ticks(3);
    pause = 1'b1;
    ticks(10);
    check("pause_drop", drop_req, 1'b0);
    check("pause_lock", lock_req, 1'b0);
    pause = 1'b0;
    expect_drop_after("pause_resume", 5);
    pause = 1'b1;
    ack_drop("pause_ack");
    pause = 1'b0;

    // async reset mid-handshake
    expect_drop_after("pre_rst", 8);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_drop", drop_req, 1'b0);
    check("rst_async_ovr", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
    expect_drop_after("post_rst", 8);
    ack_drop("post_rst_ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tetris_gravity_timer.md
# tetris_gravity_timer

Consumes the one-cycle periodic tick strobe from the game clock divider and turns it into gravity events for the Tetris game FSM. Decides when the falling piece moves down one row (level-scaled interval, soft-drop override) and when a landed piece locks after a grace delay. Each event is presented as a request/acknowledge handshake so a busy game FSM never loses one.

## Interface
- BASE_TICKS, 8: drop interval in ticks at level 0; must be 1..255
- LOCK_TICKS, 2: ticks a piece may rest on the stack before lock; must be 1..255
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle strobe from the clock divider
- enable  input  1  game running; low forces IDLE
- pause  input  1  freezes counters and state
- level  input  4  current level, 0..15
- soft_drop  input  1  player holds down; interval forced to 1 tick
- landed  input  1  piece cannot move down (combinational from the game FSM)
- drop_ack  input  1  game FSM accepted drop_req
- lock_ack  input  1  game FSM accepted lock_req
- drop_req  output  1  request: move piece down one row
- lock_req  output  1  request: lock piece into the stack
- overrun  output  1  sticky: a tick expired while a request was pending

## Operation
- Interval I = soft_drop ? 1 : max(BASE_TICKS − level, 1), 8-bit unsigned; recomputed every cycle.
- Tick counter cnt (8 bit) counts ticks in the current state; cleared on every state entry.
- States and transitions:
  - IDLE: outputs low, cnt = 0. Go to COUNT when enable = 1.
  - COUNT: on tick, if cnt + 1 ≥ I the interval expires. On expiry, go to LOCK_WAIT if landed = 1, otherwise go to DROP_REQ. Without expiry, cnt increments.
  - DROP_REQ: drop_req = 1 until drop_ack = 1, then go to COUNT. Ticks are not counted here.
  - LOCK_WAIT: on tick, cnt increments. If landed falls, go to COUNT. When cnt + 1 ≥ LOCK_TICKS on a tick, go to LOCK_REQ.
  - LOCK_REQ: lock_req = 1 until lock_ack = 1, then go to COUNT.
- The expiry compare is ≥, not ==. A level raise or soft_drop press mid-count therefore expires on the next tick, never after wrap-around.
- landed has priority over tick in LOCK_WAIT. A tick and a falling landed in the same cycle go to COUNT.
- pause = 1: state, cnt and the request outputs are all held. Ticks are ignored. Acks are still accepted and complete their handshake.
- enable = 0: go to IDLE next cycle from any state. Pending requests drop. overrun is cleared.
- Acks outside the matching request state are ignored.

## Timing
- All outputs are registered. Reset value of every output is 0, state is IDLE, cnt = 0.
- drop_req/lock_req rise on the clock edge after the expiring tick cycle (latency 1).
- An ack sampled high while its request is high drops the request on the next edge. COUNT resumes that edge with cnt = 0.
- Minimum spacing between drop_req rising edges, for I = 1 and an immediate ack, is 1 tick period.
- An asynchronous rst assertion mid-handshake clears the request immediately, independent of clk. The next request needs a full interval after release.

## Configuration
- GRAVITY_OVERRUN_EN defined: in DROP_REQ or LOCK_REQ, a tick with pause = 0 sets overrun. overrun clears only on rst or enable = 0.
- GRAVITY_OVERRUN_EN not defined: overrun is tied to 0 and no overrun logic is built.

## Test plan
- BASE_TICKS = 8, level = 3, landed = 0, drop_ack pulsed one cycle after each drop_req: drop_req rises one cycle after every 5th tick.
- level = 12: interval clamps to 1, so drop_req follows every tick. Then raise level from 0 to 6 with cnt = 4 and I = 8: the next tick expires.
- soft_drop held with level = 0: drop_req after every tick. On soft_drop release, the next drop needs 8 ticks.
- landed = 1 at expiry, LOCK_TICKS = 2: lock_req rises one cycle after the 2nd following tick. Repeat with landed dropping after 1 tick: lock_req stays 0 and COUNT restarts.
- drop_ack withheld across 3 ticks with GRAVITY_OVERRUN_EN defined: drop_req stays 1 and overrun goes to 1 and stays. Without the macro, overrun stays 0.
- pause during COUNT for 10 ticks: no requests and cnt unchanged. rst low while drop_req = 1: drop_req = 0 before the next clk edge.
